vector_element_sequencer: RTL
=============================

VECTOR_ELEMENT_SEQUENCER -- requirements
Module: vector_element_sequencer

Interface
REQ-001 Parameter N SHALL default to 6 and SHALL set the width of the element index and length (maximum vector length 2^N-1).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new vector operation; it is sampled only in IDLE.
REQ-005 op_type  input  1  SHALL select direction: 1 = count up (1 to vector_max), 0 = count down (vector_max to 1).
REQ-006 vector_max  input  N  SHALL give the vector length; it is latched on an accepted start.
REQ-007 stall  input  1  SHALL freeze sequencing for the current cycle when high.
REQ-008 counter  output  N  SHALL give the current element index, registered.
REQ-009 elem_valid  output  1  SHALL mark that counter is a live element this cycle (combinational: state RUN and not stall).
REQ-010 last  output  1  SHALL mark that counter equals the latched end value while in RUN (registered).
REQ-011 busy  output  1  SHALL be high in RUN and DONE.
REQ-012 done  output  1  SHALL be a single-cycle completion pulse, high only in DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 and vector_max!=0, the block SHALL latch op_type and vector_max, load counter with 1 (up) or vector_max (down), and enter RUN on the next edge.
REQ-015 In IDLE with start=1 and vector_max=0, the block SHALL go directly to DONE, leave counter at 0, and assert no elem_valid.
REQ-016 The first elem_valid SHALL occur one cycle after an accepted start (latency 1), unless stall is high.
REQ-017 In RUN with stall=0 and last=0, counter SHALL increment by 1 (up) or decrement by 1 (down) each cycle.
REQ-018 In RUN with stall=1, counter, last and state SHALL hold.
REQ-019 The end value SHALL be the latched vector_max (up) or 1 (down); last SHALL be 1 exactly while counter equals it in RUN.
REQ-020 In RUN with last=1 and stall=0, the block SHALL enter DONE and counter SHALL hold the end value.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-022 Counter SHALL hold its final value in IDLE until the next accepted start.
REQ-023 Start in RUN or DONE SHALL be ignored and not queued.
REQ-024 Changes on op_type and vector_max after acceptance SHALL NOT affect the running operation.
REQ-025 With vector_max=1, exactly one element (counter=1) SHALL be issued in either direction.
REQ-026 Counter arithmetic SHALL be N-bit unsigned and SHALL never wrap, because sequencing stops at the end value; vector_max=2^N-1 SHALL be fully supported.
REQ-027 Per operation, the number of elem_valid cycles SHALL equal the latched vector_max.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be IDLE and counter=0, last=0, busy=0, done=0, elem_valid=0.
REQ-029 rst SHALL take priority over start and stall.
REQ-030 Reset during RUN SHALL abort the operation with no done pulse.

Verification
REQ-031 Up count: op_type=1, vector_max=4, start pulse -> counter 1,2,3,4 on consecutive cycles with elem_valid=1; last with 4; done one cycle later; busy falls after done.
REQ-032 Down count with stall: op_type=0, vector_max=3, stall=1 on the 2nd RUN cycle -> counter 3,2,2,1; elem_valid low during the stall cycle; 3 valid elements; then done.
REQ-033 Empty and single vector:
  - vector_max=0 -> done one cycle after start, no elem_valid, counter=0.
  - vector_max=1 -> one element with counter=1 and last=1.
REQ-034 Full range: op_type=1, vector_max=63 -> 63 valid elements, counter ends at 63 with no wrap to 0.
REQ-035 Interference:
  - start and changed vector_max during RUN -> no effect on sequence.
  - rst at counter=2 -> all outputs 0 next cycle, no done pulse, new start accepted afterwards.

Source files
------------

// File: rtl/vector_element_sequencer.sv
// Issues element indices 1..vector_max (up) or vector_max..1 (down) for one
// vector operation, with per-cycle stall, a last-element flag and a done pulse.
module vector_element_sequencer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_type,
  input  logic [N-1:0] vector_max,
  input  logic         stall,
  output logic [N-1:0] counter,
  output logic         elem_valid,
  output logic         last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] counter_q, counter_d;
  logic [N-1:0] end_q, end_d;
  logic         up_q, up_d;
  logic         last_q, last_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    counter_d = counter_q;
    end_d     = end_q;
    up_d      = up_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vector_max != '0) begin
            up_d      = op_type;
            end_d     = op_type ? vector_max : N'(1);
            counter_d = op_type ? N'(1) : vector_max;
            last_d    = (vector_max == N'(1));
            state_d   = S_RUN;
          end else begin
            counter_d = '0;
            state_d   = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (!stall) begin
          if (last_q) begin
            // Counter holds the end value; stopping here is what prevents wrap.
            last_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            counter_d = up_q ? counter_q + N'(1) : counter_q - N'(1);
            last_d    = (counter_d == end_q);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      end_q     <= '0;
      up_q      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      end_q     <= end_d;
      up_q      <= up_d;
      last_q    <= last_d;
    end
  end

  assign counter    = counter_q;
  assign last       = last_q;
  assign elem_valid = (state_q == S_RUN) && !stall;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
